ilsj_lsu_dmem: RTL and testbench

//  Multi-cycle load/store unit with its own data-memory array.

---
 rtl/ilsj_lsu_dmem.sv | 217 +++++++++++++++++++++
 tb/tb_ilsj_lsu_dmem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ilsj_lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : ilsj_lsu_dmem
//  Description : Multi-cycle load/store unit with a private data-memory array.
//                Accepts one load/store from the core, stalls the core for
//                the request cycle plus WAIT_CYCLES+1 busy cycles, performs
//                the access, then pulses o_rdata_valid for one DONE cycle.
//                Handles byte/half/word accesses, byte-lane steering and
//                sign/zero extension of load data. o_d_rdata feeds the
//                write-back select mux.
//  Ports       : clk            clock, rising-edge
//                rst            asynchronous active-high reset
//                i_req_valid    load/store request (held while o_stall=1)
//                i_we           1=store, 0=load
//                i_funct3       access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//                i_addr         byte address
//                i_wdata_in     store data
//                o_stall        freeze PC/pipeline
//                o_d_rdata      extended load data (held until next load)
//                o_rdata_valid  one-cycle access-complete pulse
//                o_misalign_err misaligned access flag (DONE cycle only)
//  Config      : ILSJ_MISALIGN_TRAP_EN - when defined, adds o_misalign_err
//                and suppresses misaligned accesses instead of truncating
//                the address.
//  Revision    : 1.0 - initial release
// ============================================================================
module ilsj_lsu_dmem #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata_in,
    output logic        o_stall,
    output logic [31:0] o_d_rdata,
    output logic        o_rdata_valid
`ifdef ILSJ_MISALIGN_TRAP_EN
    ,
    output logic        o_misalign_err
`endif
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT    = WAIT_CYCLES[3:0];

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [2:0] c_F3_B    = 3'b000;
    localparam logic [2:0] c_F3_H    = 3'b001;
    localparam logic [2:0] c_F3_W    = 3'b010;
    localparam logic [2:0] c_F3_BU   = 3'b100;
    localparam logic [2:0] c_F3_HU   = 3'b101;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_d_rdata;

    logic [31:0]     r_mem [0:DEPTH-1];

    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rword;
    logic            w_access;
    logic            w_misalign;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;

    // Address bits above the word index are intentionally ignored so the
    // memory aliases modulo DEPTH.
    logic            w_unused_addr;
    assign w_unused_addr = ^i_addr[31:c_AW+2];

    assign w_idx    = r_addr[c_AW+1:2];
    assign w_rword  = r_mem[w_idx];
    // The access happens on the edge that leaves the last BUSY cycle.
    assign w_access = (r_state == c_ST_BUSY) && (r_cnt == 4'd0);

`ifdef ILSJ_MISALIGN_TRAP_EN
    assign w_misalign = (((r_funct3 == c_F3_H) || (r_funct3 == c_F3_HU)) && r_addr[0])
                      || ((r_funct3 == c_F3_W) && (r_addr[1:0] != 2'b00));
    assign o_misalign_err = (r_state == c_ST_DONE) && w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = w_rword[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

        w_load = 32'd0;
        case (r_funct3)
            c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_load = w_rword;
            c_F3_BU: w_load = {24'd0, w_byte};
            c_F3_HU: w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        if (w_misalign) begin
            w_load = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Store byte enables and lane-replicated write data
    // ------------------------------------------------------------------
    always_comb begin
        w_be = 4'b0000;
        w_wd = r_wdata;
        case (r_funct3)
            c_F3_B: begin
                w_be = 4'b0001 << r_addr[1:0];
                w_wd = {4{r_wdata[7:0]}};
            end
            c_F3_H: begin
                w_be = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{r_wdata[15:0]}};
            end
            c_F3_W: begin
                w_be = 4'b1111;
                w_wd = r_wdata;
            end
            default: begin
                w_be = 4'b0000;
                w_wd = r_wdata;
            end
        endcase
        if (w_misalign) begin
            w_be = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_req_valid) begin
                        r_we     <= i_we;
                        r_funct3 <= i_funct3;
                        r_addr   <= i_addr[c_AW+1:0];
                        r_wdata  <= i_wdata_in;
                        r_cnt    <= c_WAIT;
                        r_state  <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            r_d_rdata <= w_load;
                        end
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // The request still presented here belongs to the
                    // retiring instruction, so it is not re-accepted.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Memory array: never reset. The FSM is forced to IDLE asynchronously,
    // so a store interrupted by reset never reaches its access edge.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    assign o_stall       = (r_state == c_ST_BUSY) || ((r_state == c_ST_IDLE) && i_req_valid);
    assign o_rdata_valid = (r_state == c_ST_DONE);
    assign o_d_rdata     = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ilsj_lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ilsj_lsu_dmem
//  Description : Directed self-checking bench for ilsj_lsu_dmem.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ilsj_lsu_dmem;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata_in;
    logic        o_stall;
    logic [31:0] o_d_rdata;
    logic        o_rdata_valid;
`ifdef ILSJ_MISALIGN_TRAP_EN
    logic        o_misalign_err;
`endif

    int n_checks;
    int n_errors;

    ilsj_lsu_dmem #(
        .DEPTH       (1024),
        .WAIT_CYCLES (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_we           (i_we),
        .i_funct3       (i_funct3),
        .i_addr         (i_addr),
        .i_wdata_in     (i_wdata_in),
        .o_stall        (o_stall),
        .o_d_rdata      (o_d_rdata),
        .o_rdata_valid  (o_rdata_valid)
`ifdef ILSJ_MISALIGN_TRAP_EN
        ,
        .o_misalign_err (o_misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and runs it to its DONE cycle. Returns the number of
    // stalled cycles, whether DONE was reached, and the misalign flag in DONE.
    // With hold=1 the request stays asserted through the DONE cycle.
    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic hold,
                          output int stalls, output logic done, output logic mis);
        stalls = 0;
        done   = 1'b0;
        mis    = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_we        = we;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata_in  = wd;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (o_rdata_valid) begin
                done = 1'b1;
`ifdef ILSJ_MISALIGN_TRAP_EN
                mis = o_misalign_err;
`endif
                break;
            end
            if (o_stall) stalls++;
            @(negedge clk);
        end
        if (!hold) i_req_valid = 1'b0;
    endtask

    int         st;
    logic       dn;
    logic       ms;
    int         pulses;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_we        = 1'b0;
        i_funct3    = 3'd0;
        i_addr      = 32'd0;
        i_wdata_in  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_rdata", o_d_rdata, 32'd0);
        chk("rst_valid", {31'd0, o_rdata_valid}, 32'd0);
        rst = 1'b0;

        // SW then LW with latency checks
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, st, dn, ms);
        chk("sw_done", {31'd0, dn}, 32'd1);
        chk("sw_stalls", st, 32'd4);
        chk("sw_stall_done", {31'd0, o_stall}, 32'd0);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("lw_done", {31'd0, dn}, 32'd1);
        chk("lw_stalls", st, 32'd4);
        chk("lw_data", o_d_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, o_rdata_valid}, 32'd0);
        chk("rdata_held", o_d_rdata, 32'hDEADBEEF);

        // Sub-word loads
        access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, st, dn, ms);
        chk("lb_13", o_d_rdata, 32'hFFFFFFDE);
        access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, st, dn, ms);
        chk("lbu_13", o_d_rdata, 32'h000000DE);
        access(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, st, dn, ms);
        chk("lh_12", o_d_rdata, 32'hFFFFDEAD);
        access(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("lhu_10", o_d_rdata, 32'h0000BEEF);

        // SB only touches one lane; store leaves d_rdata alone
        access(1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 1'b0, st, dn, ms);
        chk("sb_keeps_rdata", o_d_rdata, 32'h0000BEEF);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("lw_after_sb", o_d_rdata, 32'hDEAD55EF);

        // SH to upper half
        access(1'b1, 3'b001, 32'h12, 32'hFFFF8001, 1'b0, st, dn, ms);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("lw_after_sh", o_d_rdata, 32'h800155EF);

        // Undefined load funct3 returns zero
        access(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("ld_f3_011", o_d_rdata, 32'h0);

        // Address wraps modulo DEPTH words (4 KiB)
        access(1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, st, dn, ms);
        access(1'b0, 3'b010, 32'h1020, 32'h0, 1'b0, st, dn, ms);
        chk("lw_wrap", o_d_rdata, 32'h12345678);

        // Reset during BUSY of SW 0x20 drops the store
        @(negedge clk);
        i_req_valid = 1'b1;
        i_we        = 1'b1;
        i_funct3    = 3'b010;
        i_addr      = 32'h20;
        i_wdata_in  = 32'h00000001;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stall_req", {31'd0, o_stall}, 32'd1);
        chk("midrst_rdata", o_d_rdata, 32'h0);
        chk("midrst_valid", {31'd0, o_rdata_valid}, 32'd0);
        i_req_valid = 1'b0;
        #1;
        chk("midrst_stall_noreq", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, st, dn, ms);
        chk("lw_after_drop", o_d_rdata, 32'h12345678);

        // Request held high through DONE: exactly one access
        access(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, st, dn, ms);
        pulses = dn ? 1 : 0;
        chk("hold_data", o_d_rdata, 32'hFFFFFFEF);
        @(negedge clk);
        i_req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_rdata_valid) pulses++;
        end
        chk("hold_pulses", pulses, 32'd1);

`ifdef ILSJ_MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, st, dn, ms);
        chk("mis_lw_flag", {31'd0, ms}, 32'd1);
        chk("mis_lw_data", o_d_rdata, 32'h0);
        @(negedge clk);
        chk("mis_flag_clear", {31'd0, o_misalign_err}, 32'd0);
        access(1'b1, 3'b001, 32'h11, 32'h0000FFFF, 1'b0, st, dn, ms);
        chk("mis_sh_flag", {31'd0, ms}, 32'd1);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, dn, ms);
        chk("mis_sh_nowrite", o_d_rdata, 32'h800155EF);
        chk("aligned_no_flag", {31'd0, ms}, 32'd0);
`else
        access(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, st, dn, ms);
        chk("lw_12_trunc", o_d_rdata, 32'h800155EF);
        access(1'b0, 3'b001, 32'h13, 32'h0, 1'b0, st, dn, ms);
        chk("lh_13_trunc", o_d_rdata, 32'hFFFF8001);
`endif
        chk("last_done", {31'd0, dn}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
